// File: rtl/textfb_mem.sv
// textfb_mem: text-mode character framebuffer (80x25 cells, two 16-bit cells per word).
// Port A serves the video renderer (pipelined, read-only, never stalls).
// Port B is shared between the CPU bus (cells + CTRL/STATUS/FILL registers) and a
// clear/scroll engine. Define TEXTFB_SCROLL_EN to build the SCROLL command; without
// it only CLEAR exists and STATUS bit1 reads 0.
module textfb_mem #(
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned WORDS    = 1000,
    parameter int unsigned ROWWORDS = 40,
    parameter logic [15:0] FILL_RST = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // video port
    input  logic        vbus_cyc_i,
    input  logic        vbus_stb_i,
    input  logic        vbus_we_i,
    input  logic [31:0] vbus_adr_i,
    input  logic [31:0] vbus_dat_i,
    input  logic [3:0]  vbus_sel_i,
    output logic        vbus_ack_o,
    output logic [31:0] vbus_dat_o,
    // CPU port
    input  logic        cbus_cyc_i,
    input  logic        cbus_stb_i,
    input  logic        cbus_we_i,
    input  logic [31:0] cbus_adr_i,
    input  logic [31:0] cbus_dat_i,
    input  logic [3:0]  cbus_sel_i,
    output logic        cbus_ack_o,
    output logic [31:0] cbus_dat_o,
    output logic        busy_o
);

    localparam logic [AWIDTH-1:0] LAST_W  = AWIDTH'(WORDS - 1);
    localparam logic [AWIDTH-1:0] SC_LAST = AWIDTH'(WORDS - ROWWORDS - 1);
    localparam logic [AWIDTH-1:0] ROW_OFS = AWIDTH'(ROWWORDS);
    localparam logic [AWIDTH-1:0] ONE     = AWIDTH'(1);
`ifdef TEXTFB_SCROLL_EN
    localparam logic SCROLL_CAP = 1'b1;
`else
    localparam logic SCROLL_CAP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR
`ifdef TEXTFB_SCROLL_EN
        ,
        S_SCRD,
        S_SCWR,
        S_SCFILL
`endif
    } state_t;

    typedef enum logic [1:0] {
        CS_ZERO,
        CS_REG,
        CS_RAM
    } csrc_t;

    logic [31:0] mem_q [0:WORDS-1];

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Video port (RAM port A)
    // ------------------------------------------------------------------
    logic              vreq;
    logic [AWIDTH-1:0] vidx;
    logic              vin;
    logic              vack_q;
    logic              vok_q;
    logic [31:0]       vrd_q;

    assign vreq = vbus_cyc_i & vbus_stb_i;
    assign vidx = vbus_adr_i[AWIDTH+1:2];
    assign vin  = (vidx <= LAST_W);

    // Ack every request one cycle later; remember whether the index was in range
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vack_q <= 1'b0;
            vok_q  <= 1'b0;
        end else begin
            vack_q <= vreq;
            if (vreq) vok_q <= vin;
        end
    end

    // Port A registered read; out-of-range indices are clamped and masked on output
    always_ff @(posedge clk_i) begin
        if (vreq) vrd_q <= mem_q[vin ? vidx : '0];
    end

    assign vbus_ack_o = vack_q;
    assign vbus_dat_o = vok_q ? vrd_q : '0;

    // ------------------------------------------------------------------
    // CPU port decode and registers
    // ------------------------------------------------------------------
    logic              creq;
    logic              creg_sel;
    logic [1:0]        cra;
    logic [AWIDTH-1:0] cidx;
    logic              cin;
    logic              cacc_reg;
    logic              cacc_cell;
    logic              cack_q;
    csrc_t             csrc_q;
    logic [31:0]       creg_q;
    logic [15:0]       fill_q;
    logic              start_clr_q;
`ifdef TEXTFB_SCROLL_EN
    logic              start_scr_q;
`endif
    logic [31:0]       pb_q;

    assign busy_o    = (state_q != S_IDLE);
    assign creq      = cbus_cyc_i & cbus_stb_i & ~cack_q;
    assign creg_sel  = cbus_adr_i[AWIDTH+2];
    assign cra       = cbus_adr_i[3:2];
    assign cidx      = cbus_adr_i[AWIDTH+1:2];
    assign cin       = (cidx <= LAST_W);
    assign cacc_reg  = creq & creg_sel;
    // Cell accesses wait out the engine; start_clr_q covers the launch cycle
    assign cacc_cell = creq & ~creg_sel & ~busy_o & ~start_clr_q
`ifdef TEXTFB_SCROLL_EN
                       & ~start_scr_q
`endif
                       ;

    // CPU handshake, register file and engine launch requests
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cack_q      <= 1'b0;
            csrc_q      <= CS_ZERO;
            creg_q      <= '0;
            fill_q      <= FILL_RST;
            start_clr_q <= 1'b0;
`ifdef TEXTFB_SCROLL_EN
            start_scr_q <= 1'b0;
`endif
        end else begin
            cack_q      <= cacc_reg | cacc_cell;
            start_clr_q <= 1'b0;
`ifdef TEXTFB_SCROLL_EN
            start_scr_q <= 1'b0;
`endif
            if (cacc_reg) begin
                csrc_q <= CS_REG;
                case (cra)
                    2'd0:    creg_q <= {30'h0, SCROLL_CAP, busy_o};
                    2'd1:    creg_q <= {16'h0, fill_q};
                    default: creg_q <= '0;
                endcase
                if (cbus_we_i) begin
                    case (cra)
                        2'd0: begin
                            // Commands only start from idle; CLEAR has priority
                            if (cbus_sel_i[0] && !busy_o) begin
                                if (cbus_dat_i[0]) begin
                                    start_clr_q <= 1'b1;
`ifdef TEXTFB_SCROLL_EN
                                end else if (cbus_dat_i[1]) begin
                                    start_scr_q <= 1'b1;
`endif
                                end
                            end
                        end
                        2'd1: begin
                            if (cbus_sel_i[0]) fill_q[7:0]  <= cbus_dat_i[7:0];
                            if (cbus_sel_i[1]) fill_q[15:8] <= cbus_dat_i[15:8];
                        end
                        default: ;
                    endcase
                end
            end else if (cacc_cell) begin
                csrc_q <= (!cbus_we_i && cin) ? CS_RAM : CS_ZERO;
            end
        end
    end

    // Read-data source selected by the last accepted access
    always_comb begin
        cbus_dat_o = '0;
        case (csrc_q)
            CS_REG:  cbus_dat_o = creg_q;
            CS_RAM:  cbus_dat_o = pb_q;
            default: cbus_dat_o = '0;
        endcase
    end

    assign cbus_ack_o = cack_q;

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------

    // Engine state and word counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Engine next state: clear sweeps all words; scroll alternates read/write then fills the last row
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_clr_q) state_d = S_CLEAR;
`ifdef TEXTFB_SCROLL_EN
                else if (start_scr_q) state_d = S_SCRD;
`endif
            end
            S_CLEAR: begin
                if (cnt_q == LAST_W) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
`ifdef TEXTFB_SCROLL_EN
            S_SCRD: state_d = S_SCWR;
            S_SCWR: begin
                cnt_d   = cnt_q + ONE;
                state_d = (cnt_q == SC_LAST) ? S_SCFILL : S_SCRD;
            end
            S_SCFILL: begin
                if (cnt_q == LAST_W) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM port B (engine or CPU, never both in the same cycle)
    // ------------------------------------------------------------------
    logic [3:0]        pb_we;
    logic              pb_re;
    logic [AWIDTH-1:0] pb_addr;
    logic [31:0]       pb_wdata;

    // Port B owner mux; writes are suppressed in a reset cycle so an abort leaves no extra word
    always_comb begin
        pb_we    = '0;
        pb_re    = cacc_cell & ~cbus_we_i & cin;
        pb_addr  = cin ? cidx : '0;
        pb_wdata = cbus_dat_i;
        case (state_q)
            S_CLEAR: begin
                pb_we    = '1;
                pb_re    = 1'b0;
                pb_addr  = cnt_q;
                pb_wdata = {fill_q, fill_q};
            end
`ifdef TEXTFB_SCROLL_EN
            S_SCRD: begin
                pb_re   = 1'b1;
                pb_addr = cnt_q + ROW_OFS;
            end
            S_SCWR: begin
                pb_we    = '1;
                pb_re    = 1'b0;
                pb_addr  = cnt_q;
                pb_wdata = pb_q;
            end
            S_SCFILL: begin
                pb_we    = '1;
                pb_re    = 1'b0;
                pb_addr  = cnt_q;
                pb_wdata = {fill_q, fill_q};
            end
`endif
            default: begin
                if (cacc_cell && cbus_we_i && cin) pb_we = cbus_sel_i;
            end
        endcase
        if (rst_i) pb_we = '0;
    end

    // Port B byte-enabled write and registered read
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (pb_we[b]) mem_q[pb_addr][b*8 +: 8] <= pb_wdata[b*8 +: 8];
        end
        if (pb_re) pb_q <= mem_q[pb_addr];
    end

    logic unused_inputs;
    assign unused_inputs = ^{vbus_we_i, vbus_dat_i, vbus_sel_i,
                             vbus_adr_i[31:AWIDTH+2], vbus_adr_i[1:0],
                             cbus_adr_i[31:AWIDTH+3], cbus_adr_i[1:0]};

endmodule

// File: tb/tb_textfb_mem.sv
// Directed bench for textfb_mem; follows TEXTFB_SCROLL_EN to pick scroll expectations.
module tb_textfb_mem;

    localparam int unsigned WORDS  = 1000;
    localparam int unsigned ROWW   = 40;
    localparam logic [31:0] A_CTRL = 32'h0000_1000;
    localparam logic [31:0] A_FILL = 32'h0000_1004;
`ifdef TEXTFB_SCROLL_EN
    localparam logic [31:0] STAT_CAP = 32'h0000_0002;
`else
    localparam logic [31:0] STAT_CAP = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vbus_cyc = 1'b0, vbus_stb = 1'b0, vbus_we = 1'b0;
    logic [31:0] vbus_adr = '0, vbus_dat_w = '0;
    logic [3:0]  vbus_sel = 4'hF;
    logic        vbus_ack;
    logic [31:0] vbus_dat_r;
    logic        cbus_cyc = 1'b0, cbus_stb = 1'b0, cbus_we = 1'b0;
    logic [31:0] cbus_adr = '0, cbus_dat_w = '0;
    logic [3:0]  cbus_sel = 4'hF;
    logic        cbus_ack;
    logic [31:0] cbus_dat_r;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    logic [31:0] model [0:WORDS-1];

    textfb_mem #(
        .AWIDTH  (10),
        .WORDS   (WORDS),
        .ROWWORDS(ROWW),
        .FILL_RST(16'h0000)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .vbus_cyc_i(vbus_cyc),
        .vbus_stb_i(vbus_stb),
        .vbus_we_i (vbus_we),
        .vbus_adr_i(vbus_adr),
        .vbus_dat_i(vbus_dat_w),
        .vbus_sel_i(vbus_sel),
        .vbus_ack_o(vbus_ack),
        .vbus_dat_o(vbus_dat_r),
        .cbus_cyc_i(cbus_cyc),
        .cbus_stb_i(cbus_stb),
        .cbus_we_i (cbus_we),
        .cbus_adr_i(cbus_adr),
        .cbus_dat_i(cbus_dat_w),
        .cbus_sel_i(cbus_sel),
        .cbus_ack_o(cbus_ack),
        .cbus_dat_o(cbus_dat_r),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    // Count cycles with busy high
    always @(posedge clk) begin
        #1;
        if (busy) busy_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU transfer; returns read data and edges until ack, then idles one cycle
    task automatic cbus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdata, output int waited);
        cbus_cyc   = 1'b1;
        cbus_stb   = 1'b1;
        cbus_we    = we;
        cbus_adr   = adr;
        cbus_dat_w = dat;
        cbus_sel   = sel;
        waited     = 0;
        rdata      = '0;
        do begin
            tick();
            waited++;
        end while (!cbus_ack && waited < 3000);
        if (cbus_ack) rdata = cbus_dat_r;
        else check("cbus_timeout", {31'h0, cbus_ack}, 32'h1);
        cbus_cyc = 1'b0;
        cbus_stb = 1'b0;
        cbus_we  = 1'b0;
        tick();
    endtask

    task automatic cwrite(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        int w;
        cbus_xfer(1'b1, adr, dat, 4'hF, rd, w);
    endtask

    task automatic cread(input logic [31:0] adr, output logic [31:0] rd, output int w);
        cbus_xfer(1'b0, adr, 32'h0, 4'hF, rd, w);
    endtask

    task automatic preload_ramp();
        for (int unsigned i = 0; i < WORDS; i++) begin
            cwrite(32'(i * 4), 32'(i));
            model[i] = 32'(i);
        end
    endtask

    // Back-to-back video reads of n words from 'first', compared against model
    task automatic vbus_burst(input int unsigned first, input int unsigned n, input string tag);
        logic [31:0] exp;
        check({tag, "_ack_pre"}, {31'h0, vbus_ack}, 32'h0);
        for (int unsigned i = 0; i < n; i++) begin
            vbus_cyc = 1'b1;
            vbus_stb = 1'b1;
            vbus_adr = 32'((first + i) * 4);
            tick();
            exp = (first + i < WORDS) ? model[first + i] : 32'h0;
            check($sformatf("%s_ack%0d", tag, first + i), {31'h0, vbus_ack}, 32'h1);
            check($sformatf("%s_w%0d", tag, first + i), vbus_dat_r, exp);
        end
        vbus_cyc = 1'b0;
        vbus_stb = 1'b0;
        tick();
        check({tag, "_ack_post"}, {31'h0, vbus_ack}, 32'h0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        if (busy) check({tag, "_idle_timeout"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int w;
        int c;

        repeat (3) tick();
        check("rst_vack", {31'h0, vbus_ack}, 32'h0);
        check("rst_cack", {31'h0, cbus_ack}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_vdat", vbus_dat_r, 32'h0);
        check("rst_cdat", cbus_dat_r, 32'h0);
        rst = 1'b0;
        tick();
        cread(A_FILL, rd, w);
        check("fill_rst", rd, 32'h0);
        cread(A_CTRL, rd, w);
        check("status_idle", rd, STAT_CAP);
        check("reg_ack_lat", 32'(w), 32'd1);

        // Video burst of the first row and past the end of the array
        preload_ramp();
        vbus_burst(0, 40, "vb40");
        vbus_burst(998, 4, "vboob");

        // Video write attempt is acked with read data and does not write
        vbus_cyc   = 1'b1;
        vbus_stb   = 1'b1;
        vbus_we    = 1'b1;
        vbus_adr   = 32'h8;
        vbus_dat_w = 32'hDEAD_BEEF;
        tick();
        check("vwe_ack", {31'h0, vbus_ack}, 32'h1);
        check("vwe_dat", vbus_dat_r, 32'h2);
        vbus_cyc = 1'b0;
        vbus_stb = 1'b0;
        vbus_we  = 1'b0;
        tick();
        cread(32'h8, rd, w);
        check("vwe_nowrite", rd, 32'h2);

        // Byte-lane write
        cwrite(32'd20, 32'h0);
        cbus_xfer(1'b1, 32'd20, 32'hAABB_CCDD, 4'b0011, rd, w);
        cread(32'd20, rd, w);
        check("sel_write", rd, 32'h0000_CCDD);
        model[5] = 32'h0000_CCDD;

        // Out-of-range cell accesses are acked, write dropped, read zero
        cbus_xfer(1'b1, 32'd4000, 32'h1234_5678, 4'hF, rd, w);
        check("oob_wr_ack", 32'(w), 32'd1);
        cread(32'd4000, rd, w);
        check("oob_rd_ack", 32'(w), 32'd1);
        check("oob_rd_dat", rd, 32'h0);

        // CLEAR with a cell read stalled behind it
        cwrite(A_FILL, 32'h0000_0720);
        busy_cnt = 0;
        cwrite(A_CTRL, 32'h1);
        check("clr_busy_rise", {31'h0, busy}, 32'h1);
        cread(32'd12, rd, w);
        check("clr_stall_edges", 32'(w), 32'd1001);
        check("clr_stall_dat", rd, 32'h0720_0720);
        check("clr_busy_after", {31'h0, busy}, 32'h0);
        check("clr_busy_cycles", 32'(busy_cnt), 32'd1000);
        for (int unsigned i = 0; i < WORDS; i++) model[i] = 32'h0720_0720;
        vbus_burst(0, WORDS, "clr");

        // CTRL=3 clears; register access stays 1-cycle and a second CTRL is ignored
        cwrite(A_FILL, 32'h0000_1234);
        busy_cnt = 0;
        cwrite(A_CTRL, 32'h3);
        cread(A_CTRL, rd, w);
        check("c3_status_busy", rd, STAT_CAP | 32'h1);
        check("c3_reg_ack_lat", 32'(w), 32'd1);
        cbus_xfer(1'b1, A_CTRL, 32'h1, 4'hF, rd, w);
        check("c3_ctrl_ack_lat", 32'(w), 32'd1);
        wait_idle("c3");
        tick();
        check("c3_busy_cycles", 32'(busy_cnt), 32'd1000);
        for (int unsigned i = 0; i < WORDS; i++) model[i] = 32'h1234_1234;
        vbus_burst(0, WORDS, "c3");

        // SCROLL
        preload_ramp();
        cwrite(A_FILL, 32'h0);
        busy_cnt = 0;
        cwrite(A_CTRL, 32'h2);
`ifdef TEXTFB_SCROLL_EN
        wait_idle("scr");
        tick();
        check("scr_busy_cycles", 32'(busy_cnt), 32'd1960);
        for (int unsigned i = 0; i < WORDS; i++)
            model[i] = (i < WORDS - ROWW) ? 32'(i + ROWW) : 32'h0;
`else
        repeat (20) tick();
        check("scr_busy_cycles", 32'(busy_cnt), 32'd0);
        check("scr_busy", {31'h0, busy}, 32'h0);
`endif
        vbus_burst(0, WORDS, "scr");

        // Reset during cycle 100 of a clear
        preload_ramp();
        cwrite(A_FILL, 32'h0000_5555);
        cwrite(A_CTRL, 32'h1);
        c = busy ? 1 : 0;
        while (c < 100 && c > 0) begin
            tick();
            if (busy) c++;
            else c = 0;
        end
        check("rmid_reached", 32'(c), 32'd100);
        rst = 1'b1;
        tick();
        check("rmid_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        tick();
        cread(A_FILL, rd, w);
        check("rmid_fill", rd, 32'h0);
        for (int unsigned i = 0; i < 99; i++) model[i] = 32'h5555_5555;
        vbus_burst(0, 99, "rmid_lo");
        vbus_burst(100, WORDS - 100, "rmid_hi");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
